// File: rtl/sysctl_timers.sv
// sysctl_timers: multi-channel timer bank on the CSR bus.
// Provides a shared prescaler, per-channel one-shot/auto-reload counters, a sticky
// pending register with masks, and one combined interrupt.
// Optional feature macro: TIMERS_CAPTURE_EN (adds capture_in, capture registers
// and nchannels extra pending/mask bits).
// Ports:
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   csr_a, csr_we, csr_di CSR address / write strobe / write data
//   csr_do                registered CSR read data (0 when page not selected)
//   irq                   registered level interrupt, |(pending & mask)
//   chan_irq              registered one-cycle match pulse per channel
//   capture_in            per-channel capture triggers (TIMERS_CAPTURE_EN only)
module sysctl_timers #(
  parameter logic [3:0]  csr_addr  = 4'h0,
  parameter int unsigned nchannels = 4,
  parameter int unsigned width     = 32,
  parameter int unsigned pwidth    = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [13:0]          csr_a,
  input  logic                 csr_we,
  input  logic [31:0]          csr_di,
  output logic [31:0]          csr_do,
  output logic                 irq,
  output logic [nchannels-1:0] chan_irq
`ifdef TIMERS_CAPTURE_EN
  ,
  input  logic [nchannels-1:0] capture_in
`endif
);

`ifdef TIMERS_CAPTURE_EN
  localparam int unsigned pend_w = 2 * nchannels;
`else
  localparam int unsigned pend_w = nchannels;
`endif

  logic [width-1:0]     counter [nchannels];
  logic [width-1:0]     compare [nchannels];
  logic [nchannels-1:0] en;
  logic [nchannels-1:0] ar;
  logic [pend_w-1:0]    pending;
  logic [pend_w-1:0]    mask;
  logic [pwidth-1:0]    prescaler;
  logic [pwidth-1:0]    pcount;

`ifdef TIMERS_CAPTURE_EN
  logic [width-1:0]     capture [nchannels];
  logic [nchannels-1:0] cap_s1;
  logic [nchannels-1:0] cap_s2;
  logic [nchannels-1:0] cap_s3;
  logic [nchannels-1:0] cap_rise_c;
  assign cap_rise_c = cap_s2 & ~cap_s3;
`endif

  // Address decode
  logic       sel_c;
  logic       wr_c;
  logic       glob_c;
  logic [2:0] ch_c;
  logic [1:0] reg_c;
  logic [4:0] gaddr_c;
  logic       unused_c;

  assign sel_c    = (csr_a[13:10] == csr_addr);
  assign wr_c     = csr_we & sel_c;
  assign glob_c   = csr_a[5];
  assign ch_c     = csr_a[4:2];
  assign reg_c    = csr_a[1:0];
  assign gaddr_c  = csr_a[4:0];
  assign unused_c = ^csr_a[9:6];

  logic wr_pend_c;
  logic wr_mask_c;
  logic wr_pre_c;

  assign wr_pend_c = wr_c & glob_c & (gaddr_c == 5'd0);
  assign wr_mask_c = wr_c & glob_c & (gaddr_c == 5'd1);
  assign wr_pre_c  = wr_c & glob_c & (gaddr_c == 5'd2);

  // Shared prescaler tick; prescaler==0 ticks every cycle
  logic tick_c;
  assign tick_c = (|en) & (pcount == prescaler);

  // Per-channel write strobes and match detection (match uses pre-write values)
  logic [nchannels-1:0] wr_ctl_c;
  logic [nchannels-1:0] wr_cmp_c;
  logic [nchannels-1:0] wr_cnt_c;
  logic [nchannels-1:0] match_c;

  always_comb begin
    wr_ctl_c = '0;
    wr_cmp_c = '0;
    wr_cnt_c = '0;
    match_c  = '0;
    for (int unsigned i = 0; i < nchannels; i++) begin
      if (wr_c && !glob_c && (ch_c == 3'(i))) begin
        wr_ctl_c[i] = (reg_c == 2'd0);
        wr_cmp_c[i] = (reg_c == 2'd1);
        wr_cnt_c[i] = (reg_c == 2'd2);
      end
      match_c[i] = tick_c & en[i] & (counter[i] == compare[i]);
    end
  end

  // Pending set sources; set beats a same-cycle write-1-to-clear
  logic [pend_w-1:0] set_c;
  logic [pend_w-1:0] w1c_c;

  always_comb begin
    set_c = '0;
    set_c[nchannels-1:0] = match_c;
`ifdef TIMERS_CAPTURE_EN
    set_c[pend_w-1:nchannels] = cap_rise_c;
`endif
    w1c_c = wr_pend_c ? pend_w'(csr_di) : '0;
  end

  // Read mux
  logic [31:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    if (!glob_c) begin
      for (int unsigned i = 0; i < nchannels; i++) begin
        if (ch_c == 3'(i)) begin
          case (reg_c)
            2'd0:    rdata_c = {30'd0, ar[i], en[i]};
            2'd1:    rdata_c = 32'(compare[i]);
            2'd2:    rdata_c = 32'(counter[i]);
`ifdef TIMERS_CAPTURE_EN
            default: rdata_c = 32'(capture[i]);
`else
            default: rdata_c = '0;
`endif
          endcase
        end
      end
    end else begin
      case (gaddr_c)
        5'd0:    rdata_c = 32'(pending);
        5'd1:    rdata_c = 32'(mask);
        5'd2:    rdata_c = 32'(prescaler);
        5'd3:    rdata_c = 32'(nchannels);
        default: rdata_c = '0;
      endcase
    end
  end

  // Global state, outputs and prescaler
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do    <= '0;
      irq       <= 1'b0;
      pending   <= '0;
      mask      <= '0;
      prescaler <= '0;
      pcount    <= '0;
    end else begin
      csr_do  <= sel_c ? rdata_c : '0;
      irq     <= |(pending & mask);
      pending <= (pending & ~w1c_c) | set_c;
      if (wr_mask_c) mask <= pend_w'(csr_di);
      if (wr_pre_c) begin
        prescaler <= pwidth'(csr_di);
        pcount    <= '0;
      end else if (|en) begin
        pcount <= (pcount == prescaler) ? '0 : pcount + pwidth'(1);
      end
    end
  end

  // Channel counters; a CSR write to a channel overrides that channel's tick update
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en       <= '0;
      ar       <= '0;
      chan_irq <= '0;
      for (int unsigned i = 0; i < nchannels; i++) begin
        counter[i] <= '0;
        compare[i] <= '1;
      end
    end else begin
      chan_irq <= match_c;
      for (int unsigned i = 0; i < nchannels; i++) begin
        if (wr_ctl_c[i] || wr_cmp_c[i] || wr_cnt_c[i]) begin
          if (wr_ctl_c[i]) begin
            en[i] <= csr_di[0];
            ar[i] <= csr_di[1];
          end
          if (wr_cmp_c[i]) compare[i] <= width'(csr_di);
          if (wr_cnt_c[i]) counter[i] <= width'(csr_di);
        end else if (tick_c && en[i]) begin
          if (match_c[i]) begin
            if (ar[i]) counter[i] <= '0;
            else       en[i]      <= 1'b0;
          end else begin
            counter[i] <= counter[i] + width'(1);
          end
        end
      end
    end
  end

`ifdef TIMERS_CAPTURE_EN
  // Two-flop synchroniser plus edge history; capture sees the pre-write counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cap_s1 <= '0;
      cap_s2 <= '0;
      cap_s3 <= '0;
      for (int unsigned i = 0; i < nchannels; i++) capture[i] <= '0;
    end else begin
      cap_s1 <= capture_in;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
      for (int unsigned i = 0; i < nchannels; i++) begin
        if (cap_rise_c[i]) capture[i] <= counter[i];
      end
    end
  end
`endif

endmodule
